// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared defaults and types for the SRAM-backed FIFO controller.
package sram_fifo_pkg;
  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 4;
  localparam int OB_DEPTH = 2;
  typedef logic [AW_DEF:0] ptr_t;
endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// sram_fifo_ctrl_if: producer/consumer streams and SRAM port bundle; level exists only with SRAM_FIFO_LEVEL_EN.
interface sram_fifo_ctrl_if #(parameter int DW = 8, parameter int AW = 4);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          sram_en_w;
  logic [AW-1:0] sram_addr_w;
  logic [DW-1:0] sram_din;
  logic          sram_en_r;
  logic [AW-1:0] sram_addr_r;
  logic [DW-1:0] sram_dout;
`ifdef SRAM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
  modport slave (input in_valid, in_data, out_ready, sram_dout,
                 output in_ready, out_valid, out_data, sram_en_w, sram_addr_w, sram_din, sram_en_r, sram_addr_r, level);
  modport master (output in_valid, in_data, out_ready, sram_dout,
                  input in_ready, out_valid, out_data, sram_en_w, sram_addr_w, sram_din, sram_en_r, sram_addr_r, level);
`else
  modport slave (input in_valid, in_data, out_ready, sram_dout,
                 output in_ready, out_valid, out_data, sram_en_w, sram_addr_w, sram_din, sram_en_r, sram_addr_r);
  modport master (output in_valid, in_data, out_ready, sram_dout,
                  input in_ready, out_valid, out_data, sram_en_w, sram_addr_w, sram_din, sram_en_r, sram_addr_r);
`endif
endinterface

// File: rtl/sram_fifo_outbuf.sv
// sram_fifo_outbuf: 2-entry registered FIFO re-timing SRAM read data; head is always entry 0.
module sram_fifo_outbuf #(parameter int DW = 8) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [1:0]    cnt,
  output logic [DW-1:0] head
);
  logic [DW-1:0] e1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      e1   <= '0;
      cnt  <= '0;
    end else begin
      if (pop) head <= (cnt == 2'd1) ? din : e1;
      else if (push && cnt == 2'd0) head <= din;
      if (push && cnt == (pop ? 2'd2 : 2'd1)) e1 <= din;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: valid/ready FIFO over a 1R/1W registered-read SRAM plus 2-entry output buffer; SRAM_FIFO_LEVEL_EN adds level.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input logic clk,
  input logic rst,
  sram_fifo_ctrl_if.slave bus
);
  logic [AW:0]   wptr, rptr;
  logic          rd_pend;
  logic [1:0]    ob_cnt;
  logic [DW-1:0] ob_head;
  logic          mem_empty, mem_full, in_fire, out_fire, rd_issue;
  assign mem_empty = wptr == rptr;
  assign mem_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign in_fire   = bus.in_valid && !mem_full;
  assign out_fire  = (ob_cnt != 2'd0) && bus.out_ready;
  // Credit counts words already in outbuf or in flight from the SRAM, net of this cycle's pop.
  assign rd_issue  = !mem_empty && (({1'b0, ob_cnt} + {2'b0, rd_pend} - {2'b0, out_fire}) < 3'd2);
  assign bus.in_ready    = !mem_full;
  assign bus.sram_en_w   = in_fire;
  assign bus.sram_addr_w = wptr[AW-1:0];
  assign bus.sram_din    = bus.in_data;
  assign bus.sram_en_r   = rd_issue;
  assign bus.sram_addr_r = rptr[AW-1:0];
  assign bus.out_valid   = ob_cnt != 2'd0;
  assign bus.out_data    = ob_head;
`ifdef SRAM_FIFO_LEVEL_EN
  assign bus.level = (AW+2)'(wptr - rptr) + (AW+2)'(rd_pend) + (AW+2)'(ob_cnt);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_pend <= 1'b0;
    end else begin
      wptr    <= wptr + (AW+1)'(in_fire);
      rptr    <= rptr + (AW+1)'(rd_issue);
      rd_pend <= rd_issue;
    end
  end
  sram_fifo_outbuf #(.DW(DW)) u_outbuf (
    .clk  (clk),
    .rst  (rst),
    .push (rd_pend),
    .din  (bus.sram_dout),
    .pop  (out_fire),
    .cnt  (ob_cnt),
    .head (ob_head)
  );
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: scoreboard bench for sram_fifo_ctrl with a registered-read SRAM model; honours SRAM_FIFO_LEVEL_EN.
module tb_sram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  sram_fifo_ctrl_if #(.DW(8), .AW(4)) bus ();
  sram_fifo_ctrl #(.DW(8), .AW(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] mem [16];
  always_ff @(posedge clk) begin
    if (bus.sram_en_w) mem[bus.sram_addr_w] <= bus.sram_din;
    if (bus.sram_en_r) bus.sram_dout <= mem[bus.sram_addr_r];
  end
  logic [7:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  int lvl_max = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_unexpected: got %0h, expected no word", bus.out_data);
      end else chk("out_data", bus.out_data, exp_q.pop_front());
    end
`ifdef SRAM_FIFO_LEVEL_EN
  always @(negedge clk) if (int'(bus.level) > lvl_max) lvl_max = int'(bus.level);
`endif
  // Drives words base+start..base+n-1 until all are drained or max_c cycles elapse; entered and left at posedge+1.
  task automatic run(input int n, input int start, input int base, input int p_in, input int p_out,
                     input int max_c, output int cyc, output int drops, output int idx);
    idx = start;
    cyc = 0;
    drops = 0;
    while ((idx < n || exp_q.size() != 0) && cyc < max_c) begin
      bus.in_valid  = idx < n && $urandom_range(99) < p_in;
      bus.in_data   = 8'(base + idx);
      bus.out_ready = $urandom_range(99) < p_out;
      @(negedge clk);
      if (bus.in_valid && !bus.in_ready) drops++;
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
  endtask
  initial begin
    int cyc, drops, acc;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_en_w", bus.sram_en_w, 0);
    chk("rst_en_r", bus.sram_en_r, 0);
`ifdef SRAM_FIFO_LEVEL_EN
    chk("rst_level", bus.level, 0);
`endif
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("lat_c0_valid", bus.out_valid, 0);
    chk("lat_c0_en_w", bus.sram_en_w, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("lat_out_valid", bus.out_valid, (c == 3) ? 1 : 0);
      if (c == 1) chk("lat_c1_en_r", bus.sram_en_r, 1);
      if (c == 3) chk("lat_c3_data", bus.out_data, 8'h11);
      @(posedge clk);
      #1;
    end
    chk("lat_drained", exp_q.size(), 0);
    run(20, 0, 0, 100, 0, 30, cyc, drops, acc);
    chk("full_accepts", acc, 18);
    chk("full_in_ready", bus.in_ready, 0);
`ifdef SRAM_FIFO_LEVEL_EN
    chk("full_level", bus.level, 18);
`endif
    run(20, acc, 0, 100, 100, 100, cyc, drops, acc);
    chk("full_drain_done", cyc < 100, 1);
    chk("full_drain_accepts", acc, 20);
    run(100, 0, 0, 100, 100, 200, cyc, drops, acc);
    chk("stream_cycles", cyc, 103);
    chk("stream_drops", drops, 0);
    lvl_max = 0;
    run(1000, 0, 0, 50, 50, 5000, cyc, drops, acc);
    chk("rand_done", cyc < 5000, 1);
    chk("rand_accepts", acc, 1000);
`ifdef SRAM_FIFO_LEVEL_EN
    chk("rand_level_max", lvl_max <= 18, 1);
`endif
    run(5, 0, 8'h40, 100, 0, 5, cyc, drops, acc);
    chk("pre_rst_accepts", acc, 5);
    chk("pre_rst_out_valid", bus.out_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
`ifdef SRAM_FIFO_LEVEL_EN
    chk("mid_rst_level", bus.level, 0);
`endif
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(1, 0, 8'hA5, 100, 100, 20, cyc, drops, acc);
    chk("post_rst_cycles", cyc, 4);
    chk("post_rst_empty", bus.out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
